// File: rtl/drum_pkg.sv
// Shared constants and helpers for the drum game lane/scoring engine.
package drum_pkg;

    localparam int MULT_T1 = 8;
    localparam int MULT_T2 = 16;
    localparam int MULT_T3 = 24;
    localparam int PTS_HIT = 10;

    function automatic logic [2:0] mult_of(input logic [7:0] c);
        logic [2:0] m;
        unique case (1'b1)
            (c < 8'(MULT_T1)): m = 3'd1;
            (c >= 8'(MULT_T1) && c < 8'(MULT_T2)): m = 3'd2;
            (c >= 8'(MULT_T2) && c < 8'(MULT_T3)): m = 3'd3;
            default: m = 3'd4;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lane_shift.sv
// One scrolling note column: hit-window search and clear, shift on step,
// and the escape flag for a note falling out of the bottom slot.
module lane_shift #(
    parameter int DEPTH   = 16,
    parameter int HIT_WIN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             strike,
    input  logic             step,
    input  logic             spawn,
    output logic [DEPTH-1:0] bits,
    output logic             hit,
    output logic             escape
);

    logic [DEPTH-1:0] clr_mask;
    logic [DEPTH-1:0] kept;
    logic             found;

    // lowest note in the window is the one with the largest slot index
    always_comb begin
        clr_mask = '0;
        found    = 1'b0;
        for (int s = DEPTH - 1; s >= DEPTH - HIT_WIN; s--) begin
            if (bits[s] && !found) begin
                clr_mask[s] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign hit    = active & strike & found;
    assign kept   = hit ? (bits & ~clr_mask) : bits;
    assign escape = active & step & kept[DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            bits <= '0;
        end else if (active) begin
            if (step) begin
                bits <= {kept[DEPTH-2:0], spawn};
            end else begin
                bits <= kept;
            end
        end
    end

endmodule

// File: rtl/lane_hit_judge.sv
// Note-lane engine and hit judge: pad edge detect, per-lane judging,
// score with saturation, combo multiplier and lives bookkeeping.
module lane_hit_judge
    import drum_pkg::*;
#(
    parameter int N_LANES   = 4,
    parameter int DEPTH     = 16,
    parameter int HIT_WIN   = 2,
    parameter int SCORE_W   = 14,
    parameter int SCORE_MAX = 9999,
    parameter int LIVES     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       step,
    input  logic [N_LANES-1:0]         spawn_row,
    input  logic [N_LANES-1:0]         pad,
    output logic [N_LANES*DEPTH-1:0]   lane_bits,
    output logic [SCORE_W-1:0]         score,
    output logic [7:0]                 combo,
    output logic [2:0]                 mult,
    output logic [$clog2(LIVES+1)-1:0] lives,
    output logic                       game_over,
    output logic [N_LANES-1:0]         hit_pulse,
    output logic [N_LANES-1:0]         miss_pulse
);

    localparam int LW = $clog2(LIVES + 1);

    logic               active;
    logic [N_LANES-1:0] pad_q;
    logic [N_LANES-1:0] strike;
    logic [N_LANES-1:0] hits;
    logic [N_LANES-1:0] escs;
    logic [N_LANES-1:0] misses;

    assign active = enable & ~game_over;
    assign strike = pad & ~pad_q;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        lane_shift #(
            .DEPTH  (DEPTH),
            .HIT_WIN(HIT_WIN)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .active(active),
            .strike(strike[l]),
            .step  (step),
            .spawn (spawn_row[l]),
            .bits  (lane_bits[l*DEPTH +: DEPTH]),
            .hit   (hits[l]),
            .escape(escs[l])
        );
    end

    // a strike that found nothing in the window is a bad strike
    assign misses = (strike & ~hits & {N_LANES{active}}) | escs;

    logic [31:0]        n_hit;
    logic [31:0]        n_esc;
    logic [31:0]        gain;
    logic [31:0]        sum_s;
    logic [31:0]        combo_sum;
    logic [SCORE_W-1:0] score_n;
    logic [7:0]         combo_n;
    logic [LW-1:0]      lives_n;

    always_comb begin
        n_hit = '0;
        n_esc = '0;
        for (int l = 0; l < N_LANES; l++) begin
            n_hit = n_hit + 32'(hits[l]);
            n_esc = n_esc + 32'(escs[l]);
        end
        gain      = 32'(PTS_HIT) * n_hit * 32'(mult);
        sum_s     = 32'(score) + gain;
        score_n   = (sum_s > 32'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                             : SCORE_W'(sum_s);
        combo_sum = 32'(combo) + n_hit;
        if (|misses) begin
            combo_n = '0;
        end else if (combo_sum > 32'd255) begin
            combo_n = 8'hff;
        end else begin
            combo_n = 8'(combo_sum);
        end
        lives_n = (32'(lives) > n_esc) ? (lives - LW'(n_esc)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pad_q      <= '0;
            score      <= '0;
            combo      <= '0;
            mult       <= 3'd1;
            lives      <= LW'(LIVES);
            game_over  <= 1'b0;
            hit_pulse  <= '0;
            miss_pulse <= '0;
        end else begin
            pad_q      <= pad;
            hit_pulse  <= hits;
            miss_pulse <= misses;
            if (active) begin
                score <= score_n;
                combo <= combo_n;
                mult  <= mult_of(combo_n);
                lives <= lives_n;
                if (lives_n == '0) begin
                    game_over <= 1'b1;
                end
            end
        end
    end

endmodule
